muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 219 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle, with sign fix-up and single-edge special cases.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned PW    = 2 * XLEN;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [2:0]        r_op;
  logic              r_neg;
  logic [XLEN-1:0]   r_opnd;
  logic [PW-1:0]     r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_load;
  logic              w_step;
  logic              w_fin;

  // Operand decode at acceptance
  logic              w_is_div;
  logic              w_a_sgn;
  logic              w_b_sgn;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_neg;
  logic              w_b_zero;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;

  // Iteration datapath
  logic [XLEN-1:0]   w_hi;
  logic [XLEN-1:0]   w_lo;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [PW-1:0]     w_mul_next;
  logic [PW-1:0]     w_div_next;
  logic [PW-1:0]     w_acc_step;
  logic [PW-1:0]     w_acc_neg;
  logic [XLEN-1:0]   w_lo_neg;
  logic [XLEN-1:0]   w_hi_neg;
  logic [XLEN-1:0]   w_final;

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

  // Classify the request and form operand magnitudes and the sign fix-up flag
  always_comb begin
    w_is_div = funct3[2];
    w_a_sgn  = w_is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    w_b_sgn  = w_is_div ? ~funct3[0] : ~funct3[1];
    w_a_neg  = w_a_sgn & rs1_data[XLEN-1];
    w_b_neg  = w_b_sgn & rs2_data[XLEN-1];
    w_a_mag  = w_a_neg ? (~rs1_data + XLEN'(1)) : rs1_data;
    w_b_mag  = w_b_neg ? (~rs2_data + XLEN'(1)) : rs2_data;
    // MULHSU and REM follow operand A's sign only; unsigned ops see no negatives
    if (funct3 == F_MULHSU || funct3 == F_REM) begin
      w_neg = w_a_neg;
    end else begin
      w_neg = w_a_neg ^ w_b_neg;
    end
    w_b_zero  = (rs2_data == '0);
    w_ovf     = w_is_div & ~funct3[0] & (rs1_data == MIN_NEG) & (rs2_data == ALL_ONES);
    w_special = w_is_div & (w_b_zero | w_ovf);
    if (w_b_zero) begin
      w_special_res = funct3[1] ? rs1_data : ALL_ONES;
    end else begin
      w_special_res = funct3[1] ? '0 : MIN_NEG;
    end
  end

  // One shift-add or restoring-divide step on the accumulator
  always_comb begin
    w_hi       = r_acc[PW-1:XLEN];
    w_lo       = r_acc[XLEN-1:0];
    w_sum      = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opnd} : '0);
    w_mul_next = {w_sum, w_lo[XLEN-1:1]};
    w_shift    = {w_hi, w_lo[XLEN-1]};
    w_ge       = (w_shift >= {1'b0, r_opnd});
    w_diff     = w_shift[XLEN-1:0] - r_opnd;
    if (w_ge) begin
      w_div_next = {w_diff, w_lo[XLEN-2:0], 1'b1};
    end else begin
      w_div_next = {w_shift[XLEN-1:0], w_lo[XLEN-2:0], 1'b0};
    end
    w_acc_step = r_op[2] ? w_div_next : w_mul_next;
  end

  // Final result selection with sign fix-up applied to the last step's value
  always_comb begin
    w_acc_neg = ~w_acc_step + PW'(1);
    w_lo_neg  = ~w_acc_step[XLEN-1:0] + XLEN'(1);
    w_hi_neg  = ~w_acc_step[PW-1:XLEN] + XLEN'(1);
    w_final   = '0;
    case (r_op)
      F_MUL:                    w_final = r_neg ? w_acc_neg[XLEN-1:0] : w_acc_step[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: w_final = r_neg ? w_acc_neg[PW-1:XLEN] : w_acc_step[PW-1:XLEN];
      F_DIV, F_DIVU:            w_final = r_neg ? w_lo_neg : w_acc_step[XLEN-1:0];
      F_REM, F_REMU:            w_final = r_neg ? w_hi_neg : w_acc_step[PW-1:XLEN];
      default:                  w_final = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control strobes
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_fin        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = w_special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(XLEN - 1)) begin
          w_fin        = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand capture and iteration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= '0;
      r_neg  <= 1'b0;
      r_opnd <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_op   <= funct3;
      r_neg  <= w_neg;
      r_opnd <= w_is_div ? w_b_mag : w_a_mag;
      r_acc  <= {XLEN'(0), (w_is_div ? w_a_mag : w_b_mag)};
      r_cnt  <= '0;
    end else if (w_step) begin
      r_acc  <= w_acc_step;
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  // Registered outputs; result only moves on the edge entering DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_busy <= (w_state_next == S_CALC);
      r_done <= (w_state_next == S_DONE);
      if (w_load && w_special) begin
        r_result <= w_special_res;
      end else if (w_fin) begin
        r_result <= w_final;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: an acceptance model pushes expected
// results; a negedge monitor pops and compares whenever done is seen.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rs1 = 32'h0;
  logic [31:0] rs2 = 32'h0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          next_free = 0;
  int          busy_from = 0;
  int          busy_to = 0;
  logic [31:0] exp_result = 32'h0;
  logic        finishing = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1),
    .rs2_data (rs2),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  // Architectural reference: plain 64-bit arithmetic and RISC-V corner rules
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'b000: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      3'b001: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
      3'b010: begin p = longint'($signed(a)) * longint'({32'h0, b}); return p[63:32]; end
      3'b011: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Acceptance model: start is taken only when the unit is free again
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (rst) begin
      next_free = cyc + 1;
      busy_to   = 0;
    end else if (start && cyc >= next_free) begin
      e.res = ref_res(funct3, rs1, rs2);
      e.acc = cyc;
      if (is_special(funct3, rs1, rs2)) begin
        e.lat     = 0;
        next_free = cyc + 2;
      end else begin
        e.lat     = 32;
        next_free = cyc + 34;
        busy_from = cyc;
        busy_to   = cyc + 32;
      end
      q.push_back(e);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares outputs against the scoreboard away from the active edge
  initial begin
    exp_t e;
    logic eb;
    forever begin
      @(negedge clk or posedge rst);
      #1;
      if (rst) begin
        q.delete();
        exp_result = 32'h0;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_result", result, 32'h0);
      end else begin
        eb = (cyc >= busy_from) && (cyc < busy_to);
        if (done) begin
          if (q.size() == 0) begin
            n_checks = n_checks + 1;
            n_fail   = n_fail + 1;
            $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
          end else begin
            e = q.pop_front();
            chk("result", result, e.res);
            chk("done_edge", 32'(cyc), 32'(e.acc + e.lat));
            exp_result = e.res;
          end
        end else begin
          chk("result_hold", result, exp_result);
          if (q.size() > 0 && cyc >= q[0].acc + q[0].lat) begin
            n_checks = n_checks + 1;
            n_fail   = n_fail + 1;
            $display("FAIL done_timeout: got no done expected done at edge %0d (cycle %0d)", q[0].acc + q[0].lat, cyc);
            void'(q.pop_front());
          end
        end
        chk("busy", {31'h0, busy}, {31'h0, eb});
      end
      if (finishing) begin
        chk("drain", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
      end
    end
  end

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one request, scramble inputs after acceptance, wait until idle
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct3 = f;
    rs1    = a;
    rs2    = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    funct3 = 3'($urandom);
    rs1    = $urandom;
    rs2    = $urandom;
    repeat (34) @(negedge clk);
  endtask

  // Stimulus
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // abort a multiply with reset, then rerun it
    @(negedge clk);
    funct3 = 3'b000; rs1 = 32'd7; rs2 = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_op(3'b000, 32'd7, 32'd6);

    // directed corners
    do_op(3'b001, 32'hFFFF_FFFF, 32'h0000_0002);
    do_op(3'b011, 32'hFFFF_FFFF, 32'h0000_0002);
    do_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0002);
    do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'b100, 32'hFFFF_FFF9, 32'h0000_0002);
    do_op(3'b110, 32'hFFFF_FFF9, 32'h0000_0002);
    do_op(3'b101, 32'hFFFF_FFF9, 32'h0000_0002);
    do_op(3'b100, 32'd5, 32'd0);
    do_op(3'b111, 32'd5, 32'd0);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'b000, 32'h1234_5678, 32'd0);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom), pick_opnd(), pick_opnd());
    end

    // start held high with operands changing every cycle
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 110; i++) begin
      funct3 = 3'($urandom);
      rs1    = $urandom;
      rs2    = $urandom | 32'h2;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (40) @(negedge clk);
    finishing = 1'b1;
  end

endmodule
